// File: rtl/led_ctrl_if.sv
// Button/mode/LED bundle between a board-level driver and the LED controller.
// The master drives the raw buttons and the mode select; the slave returns the LED drive and the debounced buttons.
interface led_ctrl_if #(
   parameter int NUM_BTN = 2,
   parameter int NUM_LED = 4
);
   logic [NUM_BTN-1:0] btn;
   logic [1:0]         mode;
   logic [NUM_LED-1:0] led;
   logic [NUM_BTN-1:0] db_btn;

   modport master (
      output btn,
      output mode,
      input  led,
      input  db_btn
   );

   modport slave (
      input  btn,
      input  mode,
      output led,
      output db_btn
   );
endinterface

// File: rtl/led_ctrl.sv
// LED controller: synchronises and debounces push-buttons, then drives LEDs in one of
// four modes (decode, up/down count, rotating shift, blinking decode) from a registered output.
module led_ctrl #(
   parameter int NUM_BTN     = 2,
   parameter int NUM_LED     = 4,
   parameter int DB_CYCLES   = 4,
   parameter int TICK_CYCLES = 8
) (
   input  logic      clk,
   input  logic      rst,
   led_ctrl_if.slave bus
);

   localparam int DB_W = $clog2(DB_CYCLES);
   localparam int TK_W = $clog2(TICK_CYCLES);

   typedef enum logic [1:0] {
      MODE_DECODE = 2'b00,
      MODE_COUNT  = 2'b01,
      MODE_SHIFT  = 2'b10,
      MODE_BLINK  = 2'b11
   } mode_e;

   mode_e              mode;
   logic [NUM_BTN-1:0] sync1;
   logic [NUM_BTN-1:0] sync2;
   logic [NUM_BTN-1:0] db;
   logic [DB_W-1:0]    stab [NUM_BTN];
   logic [1:0]         db_prev;
   logic [1:0]         rise;
   logic [TK_W-1:0]    tick_cnt;
   logic               tick;
   logic [NUM_LED-1:0] cnt;
   logic [NUM_LED-1:0] pos;
   logic               phase;
   logic [NUM_LED-1:0] dec;
   logic [NUM_LED-1:0] led_next;
   logic [NUM_LED-1:0] led_q;

   assign mode = mode_e'(bus.mode);

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= bus.btn;
         sync2 <= sync1;
      end
   end

   // A bit only flips after DB_CYCLES back-to-back cycles of disagreement; any agreement restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         db <= '0;
         for (int i = 0; i < NUM_BTN; i++) begin
            stab[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_BTN; i++) begin
            if (sync2[i] != db[i]) begin
               if (stab[i] == DB_W'(DB_CYCLES - 1)) begin
                  db[i]   <= sync2[i];
                  stab[i] <= '0;
               end else begin
                  stab[i] <= stab[i] + 1'b1;
               end
            end else begin
               stab[i] <= '0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         db_prev <= '0;
      end else begin
         db_prev <= db[1:0];
      end
   end

   assign rise = db[1:0] & ~db_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   assign tick = (tick_cnt == TK_W'(TICK_CYCLES - 1));

   // Pressing both count buttons at once cancels out, so only a lone rise moves the counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (mode == MODE_COUNT) begin
         case (rise)
            2'b01:   cnt <= cnt + 1'b1;
            2'b10:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pos <= NUM_LED'(1);
      end else if (mode == MODE_SHIFT && tick) begin
         if (db[0]) begin
            pos <= {pos[0], pos[NUM_LED-1:1]};
         end else begin
            pos <= {pos[NUM_LED-2:0], pos[NUM_LED-1]};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase <= 1'b0;
      end else if (mode == MODE_BLINK && tick) begin
         phase <= ~phase;
      end
   end

   // Button value v lights LED v-1; zero lights nothing.
   always_comb begin
      dec = '0;
      for (int i = 0; i < NUM_LED; i++) begin
         if (int'(db) == i + 1) begin
            dec[i] = 1'b1;
         end
      end
   end

   always_comb begin
      led_next = '0;
      case (mode)
         MODE_DECODE: led_next = dec;
         MODE_COUNT:  led_next = cnt;
         MODE_SHIFT:  led_next = pos;
         MODE_BLINK:  led_next = phase ? dec : '0;
         default:     led_next = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         led_q <= '0;
      end else begin
         led_q <= led_next;
      end
   end

   assign bus.led    = led_q;
   assign bus.db_btn = db;

endmodule

// File: doc/led_ctrl.md
LED_CTRL -- requirements
Module: led_ctrl

Interface
REQ-001 Parameter NUM_BTN, default 2, number of push-button inputs (2..4).
REQ-002 Parameter NUM_LED, default 4, number of LED outputs; SHALL satisfy NUM_LED >= 2**NUM_BTN - 1.
REQ-003 Parameter DB_CYCLES, default 4, consecutive stable cycles required to accept a button change (>= 2).
REQ-004 Parameter TICK_CYCLES, default 8, clock cycles per shift/blink tick (>= 2).
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 btn  input  NUM_BTN  raw asynchronous push-buttons, active-high.
REQ-008 mode  input  2  mode select: 00 DECODE, 01 COUNT, 10 SHIFT, 11 BLINK; sampled every cycle.
REQ-009 led  output  NUM_LED  registered LED drive, active-high.
REQ-010 db_btn  output  NUM_BTN  debounced button state, for visibility.

Function
REQ-011 Each btn bit SHALL pass through a 2-flop synchroniser before use.
REQ-012 Per bit, db_btn SHALL toggle on the DB_CYCLES-th consecutive cycle in which the synchronised value differs from db_btn; any cycle of agreement SHALL clear that bit's stability counter.
REQ-013 Rising edge of a debounced bit (rise[i]) SHALL be a one-cycle pulse in the cycle after db_btn[i] goes 0->1.
REQ-014 A free-running tick counter SHALL pulse tick once every TICK_CYCLES cycles, counting 0..TICK_CYCLES-1 then wrapping.
REQ-015 DECODE: value v = db_btn as unsigned; v = 0 -> led all zero; v > 0 -> led one-hot with bit v-1 set.
REQ-016 COUNT: NUM_LED-bit counter cnt; rise[0] increments, rise[1] decrements, modulo 2**NUM_LED; led = cnt.
REQ-017 COUNT: simultaneous rise[0] and rise[1] SHALL leave cnt unchanged.
REQ-018 SHIFT: one-hot register pos; on tick, rotate left if db_btn[0] = 0, right if db_btn[0] = 1; led = pos; wraps MSB<->LSB.
REQ-019 BLINK: phase bit toggles on tick; led = DECODE pattern when phase = 1, zero when phase = 0.
REQ-020 led SHALL be registered: it reflects the mode-selected pattern one cycle after the pattern source changes.
REQ-021 cnt, pos and phase SHALL hold their values while their mode is not selected; mode changes SHALL NOT reset them.
REQ-022 Buttons with index >= 2 SHALL affect only DECODE/BLINK patterns.
REQ-023 Latency, button press stable from cycle 0 at the btn pin: db_btn high at cycle 2+DB_CYCLES, led updated at cycle 3+DB_CYCLES (DECODE).

Reset
REQ-024 While rst = 1 at a clock edge: led = 0, db_btn = 0, synchronisers = 0, stability and tick counters = 0, cnt = 0, pos = 1 (bit 0), phase = 0.
REQ-025 Reset SHALL take priority over all other events, including mid-debounce and mid-tick; debouncing restarts from zero after release.
REQ-026 Outputs SHALL be deterministic from the first edge with rst = 1; no reliance on initial values.

Verification
REQ-027 Defaults, mode=00, btn 00->11 held -> led = 4'b0100 at cycle 7 after the change; btn 01 -> 4'b0001; btn 10 -> 4'b0010; btn 00 -> 4'b0000.
REQ-028 Bounce: btn[0] toggled every 2 cycles for 20 cycles, then held 0 -> db_btn and led never change.
REQ-029 mode=01, five clean btn[0] presses -> led = 4'b0101; three btn[1] presses from 0 -> led = 4'b1101 (wrap); both pressed together -> no change.
REQ-030 mode=10, btn = 00 -> led sequence 0001, 0010, 0100, 1000, 0001 at 8-cycle intervals; btn[0] held -> sequence reverses.
REQ-031 mode=11, btn = 11 -> led alternates 0000/0100 every 8 cycles; switch to 01 and back -> cnt value preserved.
REQ-032 rst asserted for 1 cycle mid-debounce and mid-COUNT (cnt = 5) -> next cycle led = 0, cnt = 0, pos = 0001, db_btn = 0.
